// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART transmitter/receiver pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_DEFAULT_BAUD_DIV = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_fifo_buf.sv
// ============================================================================
// Module : uart_tx_fifo_buf
// Brief  : Synchronous FIFO with push/pop, full/empty and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_buf
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly AW bits wide, so wrap-around is free for power-of-two depths.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule : uart_tx_fifo_buf

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Buffered 8N1 UART transmitter; optional even parity when the
//          macro UART_TX_PARITY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          srst_n_i,
  input  logic [UART_DATA_BITS-1:0]     data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [15:0]                baud_q, baud_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0]  sreg_q, sreg_d;
  logic                       tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [UART_DATA_BITS-1:0]  fifo_rdata;
  logic                       baud_tick;

  assign fifo_push = valid_i && ready_o && srst_n_i;
  assign ready_o   = !fifo_full;
  assign busy_o    = (state_q != IDLE) || !fifo_empty;
  assign tx_o      = tx_q;
  assign baud_tick = (baud_q == 16'd0);

  uart_tx_fifo_buf #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk_i    (clk_i),
    .srst_n_i (srst_n_i),
    .push_i   (fifo_push),
    .wdata_i  (data_i),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count_o)
  );

  // tx_d reflects the current state; registering it gives a glitch-free line.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_tick ? baud_q : baud_q - 16'd1;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    tx_d      = 1'b1;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sreg_d   = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          state_d  = START;
          baud_d   = BAUD_LOAD;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d   = DATA;
          baud_d    = BAUD_LOAD;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        tx_d = sreg_q[0];
        if (baud_tick) begin
          sreg_d    = sreg_q >> 1;
          baud_d    = BAUD_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (baud_tick) begin
          state_d   = STOP;
          baud_d    = BAUD_LOAD;
          bit_cnt_d = 3'd0;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          baud_d    = BAUD_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = 3'd0;
            // Refill on the last stop cycle so the next start bit follows with no gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sreg_d   = fifo_rdata;
`ifdef UART_TX_PARITY_EN
              parity_d = ^fifo_rdata;
`endif
              state_d  = START;
            end else begin
              state_d  = IDLE;
              baud_d   = 16'd0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
      sreg_q    <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule : uart_tx_fifo

`default_nettype wire
